// File: rtl/lab_ui_pkg.sv
// -----------------------------------------------------------------------------
// lab_ui_pkg
// Shared constants for the lab user-interface blocks: which pushbutton does
// what, the board-rate debounce interval, the digit count of the display, and
// a helper for modulo-RADIX digit stepping.
// No ports (package).
// -----------------------------------------------------------------------------
package lab_ui_pkg;

    localparam int KEY_INC    = 0;
    localparam int KEY_DEC    = 1;
    localparam int KEY_NEXT   = 2;
    localparam int KEY_COMMIT = 3;

    // 10 ms at the 24 MHz board clock
    localparam int DEBOUNCE_24MHZ_10MS = 240000;

    localparam int NUM_DIGITS = 4;

    // Step one digit up or down, wrapping inside 0..radix-1.
    function automatic logic [3:0] digit_step(input logic [3:0] d,
                                              input logic       up,
                                              input logic [3:0] max_digit);
        logic [3:0] res;
        if (up) begin
            res = (d >= max_digit) ? 4'd0 : d + 4'd1;
        end else begin
            res = (d == 4'd0) ? max_digit : d - 4'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/key_digit_entry_if.sv
// -----------------------------------------------------------------------------
// key_digit_entry_if
// Bundles the raw pushbuttons and the entry block's outputs.
//   key         : raw pushbuttons, 0 = pressed
//   key_press   : one-cycle pulse per accepted press, bit n for key[n]
//   digits      : value being edited, digit i in bits [4i+3:4i]
//   cursor      : index of the digit being edited, 0 = rightmost
//   value       : last committed digits
//   value_valid : one-cycle pulse when value updates
// Modports: slave = the entry block, master = whatever drives the keys and
// consumes the results.
// -----------------------------------------------------------------------------
interface key_digit_entry_if;

    logic [3:0]  key;
    logic [3:0]  key_press;
    logic [15:0] digits;
    logic [1:0]  cursor;
    logic [15:0] value;
    logic        value_valid;

    modport slave (
        input  key,
        output key_press,
        output digits,
        output cursor,
        output value,
        output value_valid
    );

    modport master (
        output key,
        input  key_press,
        input  digits,
        input  cursor,
        input  value,
        input  value_valid
    );

endinterface

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// One pushbutton: two-flop synchroniser, stability counter, debounced state
// and a registered press pulse on each accepted 1->0 transition.
// Ports:
//   i_clk     : board clock
//   i_rst     : synchronous active-high reset
//   i_key     : raw key, 0 = pressed, asynchronous
//   o_press   : one-cycle pulse, the cycle after the debounced state falls
// -----------------------------------------------------------------------------
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 240000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_key,
    output logic o_press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic             r_stable_d;
    logic [CNT_W-1:0] r_cnt;
    logic             r_press;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_stable   <= 1'b1;
            r_stable_d <= 1'b1;
            r_cnt      <= '0;
            r_press    <= 1'b0;
        end else begin
            r_sync1    <= i_key;
            r_sync2    <= r_sync1;
            r_stable_d <= r_stable;
            // Any sample agreeing with the stable state restarts the count,
            // so only an unbroken run of DEBOUNCE_CYCLES samples is accepted.
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            // Falling edge of the debounced state only; releases are silent.
            r_press <= r_stable_d & ~r_stable;
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/key_digit_entry.sv
// -----------------------------------------------------------------------------
// key_digit_entry
// Turns the four DE1 pushbuttons into clean press pulses and uses them to
// edit a 4-digit value one digit at a time, then commit it.
//   key[0] inc digit, key[1] dec digit, key[2] next digit, key[3] commit.
// Priority when several presses land together: commit > next > inc/dec;
// inc and dec together cancel.
// Ports:
//   clock : 24 MHz board clock, rising edge
//   reset : synchronous active-high reset
//   bus   : key_digit_entry_if slave (key in; key_press, digits, cursor,
//           value, value_valid out)
// -----------------------------------------------------------------------------
module key_digit_entry
    import lab_ui_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_24MHZ_10MS,
    parameter int RADIX           = 16
) (
    input  logic               clock,
    input  logic               reset,
    key_digit_entry_if.slave   bus
);

    localparam logic [3:0] MAX_DIGIT = 4'(RADIX - 1);

    logic [3:0]  w_press;
    logic [15:0] r_digits;
    logic [1:0]  r_cursor;
    logic [15:0] r_value;
    logic        r_value_valid;
    logic [3:0]  w_cur_digit;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .i_clk   (clock),
            .i_rst   (reset),
            .i_key   (bus.key[g]),
            .o_press (w_press[g])
        );
    end

    assign w_cur_digit = r_digits[{r_cursor, 2'b00} +: 4];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_digits      <= '0;
            r_cursor      <= '0;
            r_value       <= '0;
            r_value_valid <= 1'b0;
        end else begin
            r_value_valid <= 1'b0;
            if (w_press[KEY_COMMIT]) begin
                // Commit takes the digits as they stood before any edit
                // arriving in the same cycle; that edit is dropped.
                r_value       <= r_digits;
                r_value_valid <= 1'b1;
            end else if (w_press[KEY_NEXT]) begin
                r_cursor <= r_cursor + 2'd1;
            end else if (w_press[KEY_INC] ^ w_press[KEY_DEC]) begin
                r_digits[{r_cursor, 2'b00} +: 4] <=
                    digit_step(w_cur_digit, w_press[KEY_INC], MAX_DIGIT);
            end
        end
    end

    assign bus.key_press   = w_press;
    assign bus.digits      = r_digits;
    assign bus.cursor      = r_cursor;
    assign bus.value       = r_value;
    assign bus.value_valid = r_value_valid;

endmodule

// File: tb/tb_key_digit_entry.sv
// -----------------------------------------------------------------------------
// tb_key_digit_entry
// Directed bench for key_digit_entry with a short debounce interval.
// Two instances: u_hex (RADIX 16) and u_dec (RADIX 10).
// -----------------------------------------------------------------------------
module tb_key_digit_entry;

    localparam int DEB = 4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    int   vv_cnt_a;

    key_digit_entry_if ifa ();
    key_digit_entry_if ifb ();

    key_digit_entry #(.DEBOUNCE_CYCLES(DEB), .RADIX(16)) u_hex (
        .clock (clk),
        .reset (rst),
        .bus   (ifa)
    );

    key_digit_entry #(.DEBOUNCE_CYCLES(DEB), .RADIX(10)) u_dec (
        .clock (clk),
        .reset (rst),
        .bus   (ifb)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ifa.value_valid) vv_cnt_a++;
    end

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_key(input int sel, input logic [3:0] v);
        if (sel == 0) ifa.key = v;
        else          ifb.key = v;
    endtask

    function automatic logic [3:0] get_kp(input int sel);
        return (sel == 0) ? ifa.key_press : ifb.key_press;
    endfunction

    // Hold the keys in mask down until a press pulse appears (bounded),
    // check it, let the edit land, release and let the release settle.
    task automatic press(input int sel, input logic [3:0] mask, input string tag);
        logic [3:0] kp;
        int n;
        @(negedge clk);
        set_key(sel, ~mask);
        kp = 4'h0;
        n  = 0;
        while (kp == 4'h0 && n < 20) begin
            @(negedge clk);
            kp = get_kp(sel);
            n++;
        end
        check_val({tag, "_pulse"}, {28'd0, kp}, {28'd0, mask});
        @(negedge clk);
        set_key(sel, 4'hF);
        repeat (10) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int pulses;
        int vv0;
        n_checks = 0;
        n_errors = 0;
        vv_cnt_a = 0;
        ifa.key  = 4'hF;
        ifb.key  = 4'hF;
        rst      = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // reset state
        @(negedge clk);
        check_val("rst_key_press", {28'd0, ifa.key_press}, 32'd0);
        check_val("rst_digits", {16'd0, ifa.digits}, 32'd0);
        check_val("rst_cursor", {30'd0, ifa.cursor}, 32'd0);
        check_val("rst_value", {16'd0, ifa.value}, 32'd0);
        check_val("rst_value_valid", {31'd0, ifa.value_valid}, 32'd0);

        // press latency: pulse after the 7th rising edge, gone after the 8th
        ifa.key = 4'b1110;
        for (int e = 1; e <= 8; e++) begin
            @(negedge clk);
            if (e == 6) check_val("lat_edge6", {28'd0, ifa.key_press}, 32'd0);
            if (e == 7) check_val("lat_edge7", {28'd0, ifa.key_press}, 32'd1);
            if (e == 8) begin
                check_val("lat_edge8", {28'd0, ifa.key_press}, 32'd0);
                check_val("lat_digits", {16'd0, ifa.digits}, 32'h0001);
            end
        end
        ifa.key = 4'hF;
        repeat (10) @(negedge clk);

        // bounce: low 2, high 1, low 3, then high -> nothing accepted
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            ifa.key = (c < 2 || (c >= 3 && c < 6)) ? 4'b1110 : 4'b1111;
            @(negedge clk);
            if (ifa.key_press != 4'h0) pulses++;
        end
        check_val("bounce_pulses", pulses, 32'd0);
        check_val("bounce_digits", {16'd0, ifa.digits}, 32'h0001);

        // edit sequence from zero
        do_reset();
        press(0, 4'b0010, "dec");
        check_val("dec_wrap", {16'd0, ifa.digits}, 32'h000F);
        press(0, 4'b0100, "next1");
        press(0, 4'b0100, "next2");
        check_val("cursor2", {30'd0, ifa.cursor}, 32'd2);
        for (int i = 0; i < 3; i++) press(0, 4'b0001, "inc");
        check_val("inc3", {16'd0, ifa.digits}, 32'h030F);
        vv0 = vv_cnt_a;
        press(0, 4'b1000, "commit");
        check_val("commit_value", {16'd0, ifa.value}, 32'h030F);
        check_val("commit_vv_count", vv_cnt_a - vv0, 32'd1);
        check_val("commit_digits_kept", {16'd0, ifa.digits}, 32'h030F);
        check_val("commit_cursor_kept", {30'd0, ifa.cursor}, 32'd2);

        // decimal instance: bring digit 0 to 8, then 9, 0, 1
        for (int i = 0; i < 8; i++) press(1, 4'b0001, "dinc");
        check_val("dec_at8", {16'd0, ifb.digits}, 32'h0008);
        press(1, 4'b0001, "d9");
        check_val("dec_9", {16'd0, ifb.digits}, 32'h0009);
        press(1, 4'b0001, "d0");
        check_val("dec_wrap0", {16'd0, ifb.digits}, 32'h0000);
        press(1, 4'b0001, "d1");
        check_val("dec_1", {16'd0, ifb.digits}, 32'h0001);
        for (int i = 0; i < 5; i++) press(1, 4'b0100, "dnext");
        check_val("dec_cursor1", {30'd0, ifb.cursor}, 32'd1);

        // simultaneous presses
        do_reset();
        for (int i = 0; i < 5; i++) press(0, 4'b0001, "inc5");
        check_val("sim_pre", {16'd0, ifa.digits}, 32'h0005);
        vv0 = vv_cnt_a;
        press(0, 4'b1001, "commit_inc");
        check_val("sim_value", {16'd0, ifa.value}, 32'h0005);
        check_val("sim_digits", {16'd0, ifa.digits}, 32'h0005);
        check_val("sim_vv_count", vv_cnt_a - vv0, 32'd1);
        press(0, 4'b0011, "inc_dec");
        check_val("incdec_digits", {16'd0, ifa.digits}, 32'h0005);

        // reset mid-debounce with digit at 7
        press(0, 4'b0001, "inc6");
        press(0, 4'b0001, "inc7");
        check_val("mid_pre", {16'd0, ifa.digits}, 32'h0007);
        @(negedge clk);
        ifa.key = 4'b1110;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("mid_key_press", {28'd0, ifa.key_press}, 32'd0);
        check_val("mid_digits", {16'd0, ifa.digits}, 32'd0);
        check_val("mid_cursor", {30'd0, ifa.cursor}, 32'd0);
        check_val("mid_value", {16'd0, ifa.value}, 32'd0);
        check_val("mid_value_valid", {31'd0, ifa.value_valid}, 32'd0);
        for (int e = 1; e <= 8; e++) begin
            @(negedge clk);
            if (e == 6) check_val("held_edge6", {28'd0, ifa.key_press}, 32'd0);
            if (e == 7) check_val("held_edge7", {28'd0, ifa.key_press}, 32'd1);
            if (e == 8) begin
                check_val("held_edge8", {28'd0, ifa.key_press}, 32'd0);
                check_val("held_digits", {16'd0, ifa.digits}, 32'h0001);
            end
        end
        ifa.key = 4'hF;
        repeat (10) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
